// File: rtl/frame_deserializer.sv
// Serial-to-parallel frame receiver: start-pattern hunt, MSB-first payload, parity check, valid/ready output.
// Define FRAME_DESER_ERR_COUNT_EN to add saturating parity-error and overrun counters.
`timescale 1ns/1ps
module frame_deserializer #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    START_BITS    = 2,
  parameter logic [START_BITS-1:0] START_PATTERN = START_BITS'(2'b01),
  parameter bit                    PARITY_MODE   = 1'b0
) (
  input  logic                  controlClock,
  input  logic                  resetN,
  input  logic                  bitStrobe,
  input  logic                  serialIn,
  input  logic                  frameAbort,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  input  logic                  dataReady,
  output logic                  parityError,
  output logic                  framingError,
  output logic                  overrun,
  output logic                  busy
`ifdef FRAME_DESER_ERR_COUNT_EN
  ,
  output logic [7:0]            parityErrCount,
  output logic [7:0]            overrunCount
`endif
);

  // Widened only if the start pattern is longer than the payload counter can index.
  localparam int DW_CNT = $clog2(DATA_WIDTH+1);
  localparam int SB_CNT = $clog2(START_BITS);
  localparam int CNT_W  = (DW_CNT > SB_CNT) ? DW_CNT : SB_CNT;

  typedef enum logic [1:0] {HUNT, START, DATA, PARITY} state_t;

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] sr;
  logic [START_BITS-1:0] patShift;
  logic                  startExp, parErr, canLoad;

  // Expected start bit for the current count sits at the MSB after shifting.
  assign patShift = START_PATTERN << count;
  assign startExp = patShift[START_BITS-1];
  assign parErr   = PARITY_MODE ? (serialIn != ~^sr) : (serialIn != ^sr);
  assign canLoad  = !dataValid || dataReady;

  always_ff @(posedge controlClock or negedge resetN) begin
    if (!resetN) begin
      state        <= HUNT;
      count        <= '0;
      sr           <= '0;
      dataOut      <= '0;
      dataValid    <= 1'b0;
      parityError  <= 1'b0;
      framingError <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
`ifdef FRAME_DESER_ERR_COUNT_EN
      parityErrCount <= '0;
      overrunCount   <= '0;
`endif
    end else begin
      framingError <= 1'b0;
      overrun      <= 1'b0;
      if (dataValid && dataReady) dataValid <= 1'b0;

      if (frameAbort) begin
        state <= HUNT;
        count <= '0;
        busy  <= 1'b0;
`ifdef FRAME_DESER_ERR_COUNT_EN
        parityErrCount <= '0;
        overrunCount   <= '0;
`endif
      end else if (bitStrobe) begin
        case (state)
          HUNT: if (serialIn == START_PATTERN[START_BITS-1]) begin
            busy <= 1'b1;
            if (START_BITS == 1) begin
              state <= DATA;
              count <= '0;
            end else begin
              state <= START;
              count <= CNT_W'(1);
            end
          end
          START: begin
            if (serialIn != startExp) begin
              framingError <= 1'b1;
              state        <= HUNT;
              count        <= '0;
              busy         <= 1'b0;
            end else if (count == CNT_W'(START_BITS-1)) begin
              state <= DATA;
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
          DATA: begin
            sr <= (sr << 1) | DATA_WIDTH'(serialIn);
            if (count == CNT_W'(DATA_WIDTH-1)) begin
              state <= PARITY;
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
          PARITY: begin
            state <= HUNT;
            count <= '0;
            busy  <= 1'b0;
            if (canLoad) begin
              dataOut     <= sr;
              parityError <= parErr;
              dataValid   <= 1'b1;
`ifdef FRAME_DESER_ERR_COUNT_EN
              if (parErr && parityErrCount != 8'hFF) parityErrCount <= parityErrCount + 8'd1;
`endif
            end else begin
              overrun <= 1'b1;
`ifdef FRAME_DESER_ERR_COUNT_EN
              if (overrunCount != 8'hFF) overrunCount <= overrunCount + 8'd1;
`endif
            end
          end
          default: begin
            state <= HUNT;
            count <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_deserializer.sv
// Scoreboard bench for frame_deserializer at default parameters (8 data, start 2'b01, even parity).
`timescale 1ns/1ps
module tb_frame_deserializer;

  logic       controlClock = 1'b0;
  logic       resetN, bitStrobe, serialIn, frameAbort, dataReady;
  logic [7:0] dataOut;
  logic       dataValid, parityError, framingError, overrun, busy;
`ifdef FRAME_DESER_ERR_COUNT_EN
  logic [7:0] parityErrCount, overrunCount;
`endif

  int checks = 0, failures = 0;
  int framePulses = 0, overrunPulses = 0;
  logic [8:0] sb[$];  // {parityError, data}
  logic [8:0] expWord;

  always #5 controlClock = ~controlClock;

  frame_deserializer dut (
    .controlClock(controlClock), .resetN(resetN), .bitStrobe(bitStrobe), .serialIn(serialIn),
    .frameAbort(frameAbort), .dataOut(dataOut), .dataValid(dataValid), .dataReady(dataReady),
    .parityError(parityError), .framingError(framingError), .overrun(overrun), .busy(busy)
`ifdef FRAME_DESER_ERR_COUNT_EN
    , .parityErrCount(parityErrCount), .overrunCount(overrunCount)
`endif
  );

  // Output-side scoreboard: every transfer must match the oldest expected word.
  always @(negedge controlClock) if (resetN) begin
    if (framingError) framePulses++;
    if (overrun) overrunPulses++;
    if (dataValid && dataReady) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%h perr=%b expected=none", dataOut, parityError);
      end else begin
        expWord = sb.pop_front();
        if ({parityError, dataOut} !== expWord) begin
          failures++;
          $display("FAIL sb_word got=%h expected=%h", {parityError, dataOut}, expWord);
        end
      end
    end
  end

  task automatic tick();
    @(posedge controlClock); #1;
  endtask

  task automatic strobe(input logic b);
    bitStrobe = 1'b1; serialIn = b;
    tick();
    bitStrobe = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic badPar, input bit push, input bit readyAtParity);
    if (push) sb.push_back({badPar, d});
    strobe(1'b0); strobe(1'b1);
    for (int i = 7; i >= 0; i--) strobe(d[i]);
    if (readyAtParity) dataReady = 1'b1;
    strobe((^d) ^ badPar);
  endtask

  task automatic test_reset();
    resetN = 1'b0; bitStrobe = 1'b0; serialIn = 1'b0; frameAbort = 1'b0; dataReady = 1'b0;
    tick(); tick();
    checks++;
    if ({dataOut, dataValid, parityError, framingError, overrun, busy} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=0", {dataOut, dataValid, parityError, framingError, overrun, busy});
    end
`ifdef FRAME_DESER_ERR_COUNT_EN
    checks++;
    if ({parityErrCount, overrunCount} !== 16'd0) begin
      failures++; $display("FAIL reset_counts got=%h expected=0", {parityErrCount, overrunCount});
    end
`endif
    resetN = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || dataValid !== 1'b0) begin
      failures++; $display("FAIL reset_release busy=%b valid=%b expected=0/0", busy, dataValid);
    end
  endtask

  task automatic test_basic();
    dataReady = 1'b1;
    sendFrame(8'hA5, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dataValid !== 1'b1 || dataOut !== 8'hA5 || parityError !== 1'b0) begin
      failures++; $display("FAIL basic_word valid=%b data=%h perr=%b expected=1/a5/0", dataValid, dataOut, parityError);
    end
    tick();
    checks++;
    if (dataValid !== 1'b0) begin
      failures++; $display("FAIL basic_valid_1cycle got=%b expected=0", dataValid);
    end
  endtask

  task automatic test_parity();
    sendFrame(8'hA5, 1'b1, 1'b1, 1'b0);
    checks++;
    if (parityError !== 1'b1 || dataOut !== 8'hA5) begin
      failures++; $display("FAIL parity_err perr=%b data=%h expected=1/a5", parityError, dataOut);
    end
`ifdef FRAME_DESER_ERR_COUNT_EN
    checks++;
    if (parityErrCount !== 8'd1) begin
      failures++; $display("FAIL parity_count got=%0d expected=1", parityErrCount);
    end
`endif
    tick();
  endtask

  task automatic test_framing();
    int f0;
    f0 = framePulses;
    strobe(1'b0); strobe(1'b0);
    checks++;
    if (framingError !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL framing_pulse ferr=%b busy=%b expected=1/0", framingError, busy);
    end
    tick(); tick();
    checks++;
    if (framePulses - f0 !== 1 || dataValid !== 1'b0) begin
      failures++; $display("FAIL framing_once pulses=%0d valid=%b expected=1/0", framePulses - f0, dataValid);
    end
    sendFrame(8'h3C, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dataOut !== 8'h3C || dataValid !== 1'b1) begin
      failures++; $display("FAIL framing_recover data=%h valid=%b expected=3c/1", dataOut, dataValid);
    end
    tick(); tick();
  endtask

  task automatic test_overrun();
    int o0;
    o0 = overrunPulses;
    dataReady = 1'b0;
    sendFrame(8'h11, 1'b0, 1'b1, 1'b0);
    sendFrame(8'h22, 1'b0, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1 || dataOut !== 8'h11 || dataValid !== 1'b1) begin
      failures++; $display("FAIL overrun_drop ovr=%b data=%h valid=%b expected=1/11/1", overrun, dataOut, dataValid);
    end
`ifdef FRAME_DESER_ERR_COUNT_EN
    checks++;
    if (overrunCount !== 8'd1) begin
      failures++; $display("FAIL overrun_count got=%0d expected=1", overrunCount);
    end
`endif
    tick(); tick();
    checks++;
    if (overrunPulses - o0 !== 1) begin
      failures++; $display("FAIL overrun_once got=%0d expected=1", overrunPulses - o0);
    end
    dataReady = 1'b1;
    tick();
    checks++;
    if (dataValid !== 1'b0) begin
      failures++; $display("FAIL overrun_drain got=%b expected=0", dataValid);
    end
  endtask

  task automatic test_back_to_back();
    int o0;
    dataReady = 1'b0;
    sendFrame(8'h11, 1'b0, 1'b1, 1'b0);
    o0 = overrunPulses;
    sendFrame(8'h22, 1'b0, 1'b1, 1'b1);
    checks++;
    if (dataValid !== 1'b1 || dataOut !== 8'h22) begin
      failures++; $display("FAIL b2b_reload valid=%b data=%h expected=1/22", dataValid, dataOut);
    end
    tick();
    checks++;
    if (overrunPulses !== o0 || dataValid !== 1'b0) begin
      failures++; $display("FAIL b2b_no_overrun pulses=%0d valid=%b expected=0/0", overrunPulses - o0, dataValid);
    end
  endtask

  task automatic test_abort();
    dataReady = 1'b1;
    strobe(1'b0); strobe(1'b1);
    strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1); strobe(1'b0);
    frameAbort = 1'b1;
    tick();
    frameAbort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL abort_busy got=%b expected=0", busy);
    end
    // Abort coinciding with the parity strobe discards the frame silently.
    strobe(1'b0); strobe(1'b1);
    for (int i = 7; i >= 0; i--) strobe(i < 4);
    bitStrobe = 1'b1; serialIn = 1'b0; frameAbort = 1'b1;
    tick();
    bitStrobe = 1'b0; frameAbort = 1'b0;
    checks++;
    if (dataValid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_parity valid=%b ovr=%b busy=%b expected=0/0/0", dataValid, overrun, busy);
    end
    sendFrame(8'h5A, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dataOut !== 8'h5A) begin
      failures++; $display("FAIL abort_recover got=%h expected=5a", dataOut);
    end
    tick(); tick();
  endtask

  task automatic test_reset_midframe();
    dataReady = 1'b0;
    sendFrame(8'h77, 1'b0, 1'b1, 1'b0);
    strobe(1'b0); strobe(1'b1); strobe(1'b1);
    #2 resetN = 1'b0;
    #1;
    checks++;
    if ({dataOut, dataValid, parityError, framingError, overrun, busy} !== 13'd0) begin
      failures++;
      $display("FAIL reset_async got=%h expected=0", {dataOut, dataValid, parityError, framingError, overrun, busy});
    end
    sb.delete();
    tick();
    resetN = 1'b1;
    tick();
    dataReady = 1'b1;
    sendFrame(8'hC3, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dataOut !== 8'hC3 || dataValid !== 1'b1) begin
      failures++; $display("FAIL reset_recover data=%h valid=%b expected=c3/1", dataOut, dataValid);
    end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    tick(); tick();
    checks++;
    if (sb.size() !== 0) begin
      failures++; $display("FAIL sb_drained left=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
